// File: rtl/serializer_pkg.sv
// Shared types and constants for the word serializer.
package serializer_pkg;
  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PAR
  } state_t;
endpackage

// File: rtl/word_par_gen.sv
// Combinational even-parity reduction: output is the XOR of all data bits.
module word_par_gen
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);
  assign parity = ^data;
endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial converter with ready/valid on both sides, optional
// trailing even-parity bit and zero-bubble back-to-back frames.
module word_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          LSB_FIRST = 1'b1,
  parameter bit          PARITY_EN = 1'b0
) (
  input  logic             clock,
  input  logic             r,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);
  localparam int unsigned   CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sreg_q;
  logic             par_q;
  logic             par_in;
  logic             ready_en_q;
  logic             accept, beat, load, advance, final_beat;

  word_par_gen #(.WIDTH(WIDTH)) u_par (
    .data   (in_data),
    .parity (par_in)
  );

  always_ff @(posedge clock or negedge r) begin
    if (!r) state_q <= IDLE;
    else    state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ser_out    = 1'b0;
    ser_valid  = 1'b0;
    ser_first  = 1'b0;
    ser_last   = 1'b0;
    final_beat = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;
    in_ready   = 1'b0;
    accept     = 1'b0;
    beat       = 1'b0;

    case (state_q)
      SHIFT: begin
        ser_valid  = 1'b1;
        ser_out    = LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1];
        ser_first  = (cnt_q == '0);
        ser_last   = !PARITY_EN && (cnt_q == LAST);
        final_beat = ser_last;
      end
      PAR: begin
        ser_valid  = 1'b1;
        ser_out    = par_q;
        ser_last   = 1'b1;
        final_beat = 1'b1;
      end
      default: ;
    endcase

    // ready_en_q holds in_ready low until the first edge after reset release
    in_ready = ready_en_q && ((state_q == IDLE) || (final_beat && ser_ready));
    accept   = in_valid && in_ready;
    beat     = ser_valid && ser_ready;

    if (accept) begin
      state_d = SHIFT;
      load    = 1'b1;
    end else if (beat) begin
      if (state_q == SHIFT && cnt_q != LAST) advance = 1'b1;
      else if (state_q == SHIFT && PARITY_EN) state_d = PAR;
      else state_d = IDLE;
    end
  end

  assign busy = (state_q != IDLE);

  // The outgoing bit always sits at one fixed end of sreg_q, so it is shifted
  // toward that end on every completed data beat.
  always_ff @(posedge clock or negedge r) begin
    if (!r) begin
      cnt_q      <= '0;
      sreg_q     <= '0;
      par_q      <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (load) begin
        cnt_q  <= '0;
        sreg_q <= in_data;
        par_q  <= par_in;
      end else if (advance) begin
        cnt_q  <= cnt_q + CW'(1);
        sreg_q <= LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);
      end else if (beat && state_q == SHIFT) begin
        cnt_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: three instances (plain, parity, MSB-first)
// share stimulus; each scenario checks the instance it targets.
module tb_word_serializer;
  logic        clock = 1'b0;
  logic        r = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        ser_ready = 1'b1;
  logic [2:0]  ir, so, sv, sf, sl, bz;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  word_serializer #(.WIDTH(16), .LSB_FIRST(1'b1), .PARITY_EN(1'b0)) u_plain (
    .clock(clock), .r(r), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[0]),
    .ser_out(so[0]), .ser_valid(sv[0]), .ser_ready(ser_ready), .ser_first(sf[0]),
    .ser_last(sl[0]), .busy(bz[0]));

  word_serializer #(.WIDTH(16), .LSB_FIRST(1'b1), .PARITY_EN(1'b1)) u_par (
    .clock(clock), .r(r), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[1]),
    .ser_out(so[1]), .ser_valid(sv[1]), .ser_ready(ser_ready), .ser_first(sf[1]),
    .ser_last(sl[1]), .busy(bz[1]));

  word_serializer #(.WIDTH(16), .LSB_FIRST(1'b0), .PARITY_EN(1'b0)) u_msb (
    .clock(clock), .r(r), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[2]),
    .ser_out(so[2]), .ser_valid(sv[2]), .ser_ready(ser_ready), .ser_first(sf[2]),
    .ser_last(sl[2]), .busy(bz[2]));

  typedef struct {
    logic [15:0] data;
    int unsigned sel;     // 0 plain, 1 parity, 2 MSB-first
    int unsigned nbeats;
    logic [16:0] seq;     // bit k = expected ser_out on beat k
  } vec_t;

  vec_t vecs[8];

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    r = 1'b0; in_valid = 1'b0; ser_ready = 1'b1;
    #1 checkw("reset_outputs", 32'({so, sv, sf, sl, bz, ir}), 32'h0);
    @(negedge clock);
    r = 1'b1;
    #1 checkw("ready_before_edge", 32'(ir), 32'h0);
    @(negedge clock);
    #1 checkw("ready_after_edge", 32'(ir), 32'h7);
  endtask

  task automatic accept_word(input logic [15:0] d, input int unsigned sel);
    @(negedge clock);
    in_valid = 1'b1; in_data = d;
    #1 check1("accept_ready", ir[sel], 1'b1);
  endtask

  task automatic run_frame(input vec_t v);
    logic [16:0] seq;
    seq = v.seq;
    do_reset();
    accept_word(v.data, v.sel);
    for (int unsigned k = 0; k < v.nbeats; k++) begin
      @(negedge clock);
      in_valid = 1'b0; in_data = ~v.data;
      #1;
      check1("frame_valid", sv[v.sel], 1'b1);
      check1("frame_bit",   so[v.sel], seq[k]);
      check1("frame_first", sf[v.sel], k == 0);
      check1("frame_last",  sl[v.sel], k == v.nbeats - 1);
      check1("frame_ready", ir[v.sel], k == v.nbeats - 1);
      check1("frame_busy",  bz[v.sel], 1'b1);
    end
    @(negedge clock);
    #1;
    check1("frame_end_valid", sv[v.sel], 1'b0);
    check1("frame_end_busy",  bz[v.sel], 1'b0);
    check1("frame_end_out",   so[v.sel], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] seq16;
    logic [3:0]  pat;
    int unsigned k, c;

    vecs[0] = '{16'hA5C3, 0, 16, 17'h0A5C3};
    vecs[1] = '{16'hFFFF, 0, 16, 17'h0FFFF};
    vecs[2] = '{16'h0001, 1, 17, 17'h10001};
    vecs[3] = '{16'hA5C3, 1, 17, 17'h0A5C3};
    vecs[4] = '{16'h8000, 1, 17, 17'h18000};
    vecs[5] = '{16'h8000, 2, 16, 17'h00001};
    vecs[6] = '{16'hA5C3, 2, 16, 17'h0C3A5};
    vecs[7] = '{16'h0003, 1, 17, 17'h00003};

    for (int unsigned i = 0; i < 8; i++) run_frame(vecs[i]);

    // Backpressure: ready pattern 1,0,0,1 repeating during 0xA5C3.
    seq16 = 16'hA5C3;
    pat   = 4'b1001;
    do_reset();
    accept_word(16'hA5C3, 0);
    k = 0; c = 0;
    while (k < 16 && c < 100) begin
      @(negedge clock);
      in_valid = 1'b0;
      ser_ready = pat[c % 4];
      #1;
      check1("stall_valid", sv[0], 1'b1);
      check1("stall_bit",   so[0], seq16[k]);
      check1("stall_first", sf[0], k == 0);
      check1("stall_last",  sl[0], k == 15);
      check1("stall_ready", ir[0], (k == 15) && ser_ready);
      if (ser_ready) k++;
      c++;
    end
    checkw("stall_beats", k, 32'd16);
    @(negedge clock);
    ser_ready = 1'b1;
    #1 check1("stall_end_valid", sv[0], 1'b0);

    // Back-to-back 0xFFFF then 0x0000 with in_valid held high.
    do_reset();
    accept_word(16'hFFFF, 0);
    for (int unsigned b = 0; b < 32; b++) begin
      @(negedge clock);
      in_data = 16'h0000;
      in_valid = (b < 31);
      #1;
      check1("b2b_valid", sv[0], 1'b1);
      check1("b2b_bit",   so[0], b < 16);
      check1("b2b_ready", ir[0], (b == 15) || (b == 31));
      check1("b2b_first", sf[0], (b % 16) == 0);
      check1("b2b_last",  sl[0], (b % 16) == 15);
    end
    @(negedge clock);
    #1;
    check1("b2b_end_valid", sv[0], 1'b0);
    check1("b2b_end_busy",  bz[0], 1'b0);
    check1("b2b_end_ready", ir[0], 1'b1);

    // Reset asserted at beat 7 of a frame.
    do_reset();
    accept_word(16'hA5C3, 0);
    for (int unsigned b = 0; b < 7; b++) begin
      @(negedge clock);
      in_valid = 1'b0;
      #1 check1("abort_pre_bit", so[0], seq16[b]);
    end
    @(negedge clock);
    r = 1'b0;
    #1 checkw("abort_outputs", 32'({so[0], sv[0], sf[0], sl[0], bz[0], ir[0]}), 32'h0);
    @(negedge clock);
    r = 1'b1;
    #1 check1("abort_ready_pre", ir[0], 1'b0);
    @(negedge clock);
    #1;
    check1("abort_ready_post", ir[0], 1'b1);
    for (int unsigned b = 0; b < 20; b++) begin
      @(negedge clock);
      #1 checkw("abort_no_residual", 32'({sv, bz}), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 Parameter WIDTH, default 16, is the parallel word width in bits; legal range 2..64.
REQ-002 Parameter LSB_FIRST, default 1, selects the shift order: 1 = bit 0 first, 0 = bit WIDTH-1 first.
REQ-003 Parameter PARITY_EN, default 0, appends one even-parity bit after the data bits when set to 1.
REQ-004 Port clock, input, 1, is the single clock; all state changes on its rising edge.
REQ-005 Port r, input, 1, is the reset: asynchronous, active-low.
REQ-006 Port in_data, input, WIDTH, is the parallel word from the upstream registered stage.
REQ-007 Port in_valid, input, 1, qualifies in_data.
REQ-008 Port in_ready, output, 1, signals that the block accepts a word this cycle.
REQ-009 Port ser_out, output, 1, is the current serial bit.
REQ-010 Port ser_valid, output, 1, qualifies ser_out.
REQ-011 Port ser_ready, input, 1, is downstream backpressure.
REQ-012 Port ser_first, output, 1, marks the first bit of a frame.
REQ-013 Port ser_last, output, 1, marks the last bit of a frame.
REQ-014 Port busy, output, 1, is high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, SHIFT and PAR.
REQ-016 A word SHALL be accepted on a cycle with in_valid && in_ready; the word and its even parity (XOR of all bits) are captured, the bit counter is cleared, and the next state is SHIFT.
REQ-017 in_ready SHALL be 1 in IDLE, and also on the final beat of a frame when ser_ready=1 (zero-bubble back-to-back); it SHALL be 0 otherwise.
REQ-018 Latency: the first bit SHALL be presented with ser_valid=1 in the cycle after acceptance.
REQ-019 In SHIFT, ser_out SHALL be the current bit in LSB_FIRST order, and ser_valid SHALL be 1.
REQ-020 A beat completes only when ser_valid && ser_ready; the counter then advances by one.
REQ-021 While ser_ready=0, ser_out, ser_first and ser_last SHALL hold stable.
REQ-022 ser_first SHALL be 1 only while the counter is 0 in SHIFT.
REQ-023 ser_last SHALL be 1 on counter=WIDTH-1 when PARITY_EN=0, and in PAR when PARITY_EN=1; it SHALL be 0 on every other beat.
REQ-024 On completion of the last data beat, the FSM SHALL go to PAR if PARITY_EN=1, else to SHIFT if a new word is accepted that cycle, else to IDLE.
REQ-025 In PAR, ser_out SHALL be the stored parity bit; on completion the FSM SHALL go to SHIFT if a word is accepted that cycle, else to IDLE.
REQ-026 The counter SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1.
REQ-027 Outside SHIFT and PAR, ser_valid, ser_first and ser_last SHALL be 0 and ser_out SHALL be 0.
REQ-028 in_data changes while a frame is in flight SHALL have no effect on that frame.

Reset
REQ-029 When r=0, the block SHALL immediately force: state IDLE, counter 0, shift register 0, parity 0, ser_out/ser_valid/ser_first/ser_last/busy = 0, in_ready = 0.
REQ-030 in_ready SHALL rise on the first clock edge after r returns to 1.
REQ-031 A reset asserted mid-frame SHALL abort the frame; no partial bits are emitted after reset is released.

Structure
REQ-032 Package serializer_pkg SHALL hold the state enum (IDLE, SHIFT, PAR) and the default WIDTH constant of 16.
REQ-033 One sub-module, word_par_gen, SHALL hold the combinational even-parity reduction over WIDTH bits.

Verification
REQ-034 The bench SHALL cover the following directed scenarios:
- WIDTH=16, LSB_FIRST=1, in_data=0xA5C3, ser_ready=1 -> ser_out sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 on 16 consecutive cycles, with ser_first on beat 0 and ser_last on beat 15.
- PARITY_EN=1, in_data=0x0001 -> 16 data bits, then a 17th beat with ser_out=1 and ser_last=1.
- ser_ready toggling 1,0,0,1 during 0xA5C3 -> bits held stable while stalled, no bit lost or duplicated, frame takes 16 completed beats.
- Two words 0xFFFF then 0x0000 with in_valid held high -> 32 contiguous ser_valid cycles, in_ready=1 only on beats 15 and 31 (and in IDLE).
- r driven to 0 at beat 7 of a frame -> all outputs 0 immediately; after release, in_ready=1 one edge later and no residual bits appear.
- LSB_FIRST=0, in_data=0x8000 -> first beat ser_out=1, remaining 15 beats ser_out=0.
